// File: rtl/mem_arb_pkg.sv
// Shared types and block geometry for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ISSUE,
    DRAIN,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  localparam int          BLK_WORDS = 8;
  localparam logic [15:0] BLK_MASK  = 16'hFFF0;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates single-ported main memory between I-miss, D-miss and D-store
// traffic, sequencing 8-word block fills against fixed-latency reads.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_req,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss_req,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_fill_done,
  output logic              d_fill_done,
  output logic              busy
);

  arb_state_t        state, state_nxt;
  owner_t            owner;
  logic              last_d;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2:0]        issue_cnt;
  logic [3:0]        ret_cnt;
  logic [3:0]        ret_cnt_nxt;
  logic              ret_active;
  logic              grant_d;

  // On a tie the side that was not served by the previous fill wins.
  assign grant_d     = d_miss_req && (!i_miss_req || !last_d);
  assign ret_active  = ((state == ISSUE) || (state == DRAIN)) && mem_rvalid;
  assign ret_cnt_nxt = ret_cnt + {3'b000, ret_active};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_wr_req) begin
          state_nxt = WRITE;
        end else if (i_miss_req || d_miss_req) begin
          state_nxt = ISSUE;
        end
      end
      WRITE: state_nxt = IDLE;
      ISSUE: begin
        if (issue_cnt == 3'd7) begin
          state_nxt = DRAIN;
        end
      end
      // Look at the post-increment count so DONE follows the last return directly.
      DRAIN: begin
        if (ret_cnt_nxt == 4'(BLK_WORDS)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner     <= OWN_I;
      last_d    <= 1'b0;
      base      <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            wr_addr <= d_wr_addr;
            wr_data <= d_wr_data;
          end else if (i_miss_req || d_miss_req) begin
            owner     <= grant_d ? OWN_D : OWN_I;
            base      <= (grant_d ? d_miss_addr : i_miss_addr) & ADDR_W'(BLK_MASK);
            issue_cnt <= '0;
            ret_cnt   <= '0;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 3'd1;
          ret_cnt   <= ret_cnt_nxt;
        end
        DRAIN: ret_cnt <= ret_cnt_nxt;
        DONE:  last_d  <= (owner == OWN_D);
        default: ;
      endcase
    end
  end

  always_comb begin
    d_wr_ack    = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    busy        = (state != IDLE);
    case (state)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        d_wr_ack  = 1'b1;
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base | ADDR_W'({issue_cnt, 1'b0});
      end
      DONE: begin
        i_fill_done = (owner == OWN_I);
        d_fill_done = (owner == OWN_D);
      end
      default: ;
    endcase
  end

  // Return path is combinational so each word lands in the cache in its valid cycle.
  always_comb begin
    i_fill_we = 1'b0;
    d_fill_we = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    if (ret_active) begin
      i_fill_we = (owner == OWN_I);
      d_fill_we = (owner == OWN_D);
      fill_addr = base | ADDR_W'({ret_cnt[2:0], 1'b0});
      fill_data = mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle read-latency memory model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss_req, d_miss_req, d_wr_req;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        d_wr_ack, mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, busy;
  logic [15:0] fill_addr, fill_data;

  logic [3:0]  pv = 4'b0000;
  logic [15:0] pa [4];
  logic        inj_v = 1'b0;
  logic [15:0] inj_d = 16'h0000;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ack(d_wr_ack),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory returns addr ^ 16'h5A3C exactly four cycles after a read issue.
  always @(posedge clk) begin
    pv    <= {pv[2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    pa[1] <= pa[0];
    pa[2] <= pa[1];
    pa[3] <= pa[2];
  end

  assign mem_rvalid = pv[3] | inj_v;
  assign mem_rdata  = inj_v ? inj_d : (pv[3] ? (pa[3] ^ 16'h5A3C) : 16'h0000);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [15:0] iaddr,
                               input logic dreq, input logic [15:0] daddr);
    i_miss_req  = ireq;
    i_miss_addr = iaddr;
    d_miss_req  = dreq;
    d_miss_addr = daddr;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"}, {15'd0, busy}, 16'd0);
    checkOutput({tag, ".mem_en"}, {15'd0, mem_en}, 16'd0);
    checkOutput({tag, ".mem_addr"}, mem_addr, 16'h0000);
    checkOutput({tag, ".ack"}, {15'd0, d_wr_ack}, 16'd0);
    checkOutput({tag, ".i_we"}, {15'd0, i_fill_we}, 16'd0);
    checkOutput({tag, ".d_we"}, {15'd0, d_fill_we}, 16'd0);
  endtask

  // Request is assumed sampled in the current IDLE cycle (T); walks T+1..T+14.
  task automatic checkFill(input logic is_d, input logic [15:0] base, input int wr_k);
    logic        en_e, we_e;
    logic [15:0] a_e;
    for (int k = 1; k <= 14; k++) begin
      tick();
      en_e = (k >= 1) && (k <= 8);
      we_e = (k >= 5) && (k <= 12);
      checkOutput("fill.mem_en", {15'd0, mem_en}, {15'd0, en_e});
      checkOutput("fill.mem_wr", {15'd0, mem_wr}, 16'd0);
      checkOutput("fill.mem_addr", mem_addr, en_e ? 16'(base + 2 * (k - 1)) : 16'h0000);
      checkOutput("fill.own_we", {15'd0, is_d ? d_fill_we : i_fill_we}, {15'd0, we_e});
      checkOutput("fill.other_we", {15'd0, is_d ? i_fill_we : d_fill_we}, 16'd0);
      if (we_e) begin
        a_e = 16'(base + 2 * (k - 5));
        checkOutput("fill.fill_addr", fill_addr, a_e);
        checkOutput("fill.fill_data", fill_data, a_e ^ 16'h5A3C);
      end
      checkOutput("fill.own_done", {15'd0, is_d ? d_fill_done : i_fill_done}, {15'd0, k == 13});
      checkOutput("fill.other_done", {15'd0, is_d ? i_fill_done : d_fill_done}, 16'd0);
      checkOutput("fill.busy", {15'd0, busy}, {15'd0, k <= 13});
      checkOutput("fill.ack", {15'd0, d_wr_ack}, 16'd0);
      if (k == wr_k) d_wr_req = 1'b1;
      if (k == 13) begin
        if (is_d) d_miss_req = 1'b0;
        else      i_miss_req = 1'b0;
      end
    end
  endtask

  task automatic checkWrite(input logic [15:0] a, input logic [15:0] d);
    checkOutput("wr.mem_en", {15'd0, mem_en}, 16'd1);
    checkOutput("wr.mem_wr", {15'd0, mem_wr}, 16'd1);
    checkOutput("wr.mem_addr", mem_addr, a);
    checkOutput("wr.mem_wdata", mem_wdata, d);
    checkOutput("wr.ack", {15'd0, d_wr_ack}, 16'd1);
    checkOutput("wr.busy", {15'd0, busy}, 16'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    d_wr_req = 1'b0;
    d_wr_addr = 16'h0000;
    d_wr_data = 16'h0000;
    applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
    tick(); tick(); tick();
    checkIdle("reset");
    checkOutput("reset.mem_wdata", mem_wdata, 16'h0000);
    checkOutput("reset.fill_addr", fill_addr, 16'h0000);
    checkOutput("reset.i_done", {15'd0, i_fill_done}, 16'd0);
    checkOutput("reset.d_done", {15'd0, d_fill_done}, 16'd0);
    rst_n = 1'b1;
    tick();

    // Lone I miss, unaligned address
    applyStimulus(1'b1, 16'h0126, 1'b0, 16'h0000);
    checkFill(1'b0, 16'h0120, 0);
    checkIdle("i_alone.end");

    // Tie right after reset: D first, then I
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    applyStimulus(1'b1, 16'h0356, 1'b1, 16'h0234);
    checkFill(1'b1, 16'h0230, 0);
    checkFill(1'b0, 16'h0350, 0);

    // D alone, then a tie goes to I
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0400);
    checkFill(1'b1, 16'h0400, 0);
    applyStimulus(1'b1, 16'h0810, 1'b1, 16'h0920);
    checkFill(1'b0, 16'h0810, 0);
    checkFill(1'b1, 16'h0920, 0);

    // Store beats both misses; D fill starts reading at T+3
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    d_wr_addr = 16'h0040;
    d_wr_data = 16'hBEEF;
    d_wr_req  = 1'b1;
    applyStimulus(1'b1, 16'h0A00, 1'b1, 16'h0B00);
    tick();
    checkWrite(16'h0040, 16'hBEEF);
    d_wr_req = 1'b0;
    tick();
    checkIdle("wr_first.idle");
    checkFill(1'b1, 16'h0B00, 0);
    checkFill(1'b0, 16'h0A00, 0);

    // Store arriving mid-fill waits for the first IDLE cycle
    d_wr_addr = 16'h0C44;
    d_wr_data = 16'h1234;
    applyStimulus(1'b1, 16'h0C40, 1'b0, 16'h0000);
    checkFill(1'b0, 16'h0C40, 6);
    tick();
    checkWrite(16'h0C44, 16'h1234);
    d_wr_req = 1'b0;
    tick();
    checkIdle("wr_late.idle");

    // Reset during a fill; late and injected returns must be dropped
    applyStimulus(1'b1, 16'h0D00, 1'b0, 16'h0000);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput("rst_mid.mem_addr", mem_addr, 16'(16'h0D00 + 2 * (k - 1)));
    end
    rst_n = 1'b0;
    i_miss_req = 1'b0;
    tick();
    rst_n = 1'b1;
    checkIdle("rst_mid.t8");
    checkOutput("rst_mid.fill_addr", fill_addr, 16'h0000);
    checkOutput("rst_mid.i_done", {15'd0, i_fill_done}, 16'd0);
    for (int k = 9; k <= 13; k++) begin
      tick();
      checkIdle("rst_mid.late");
      if (k == 9) begin
        inj_d = 16'hDEAD;
        inj_v = 1'b1;
      end else begin
        inj_v = 1'b0;
      end
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 16'h0E06);
    checkFill(1'b1, 16'h0E00, 0);

    // Top-of-memory block stays inside 0xFFF0..0xFFFE
    applyStimulus(1'b1, 16'hFFF8, 1'b0, 16'h0000);
    checkFill(1'b0, 16'hFFF0, 0);
    tick();
    checkIdle("top_blk.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
